// File: rtl/tcm_dec_symb_metric.sv
// Symbol metric front end of the 4D-8PSK TCM decoder: frames four I/Q samples into a 4D symbol
// and produces the 4x8 8PSK correlation metrics through a three-stage pipeline.
module tcm_dec_symb_metric #(
  parameter int unsigned pDAT_W = 8
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic                       ival,
  input  logic                       isop,
  input  logic signed [pDAT_W-1:0]   idat_re,
  input  logic signed [pDAT_W-1:0]   idat_im,
  output logic                       oval,
  output logic [32*pDAT_W-1:0]       osymb_m,
  output logic                       oerr
);

  localparam int unsigned SW = pDAT_W + 1;
  localparam int unsigned CW = pDAT_W + 2;
  localparam int unsigned PW = SW + 9;

  typedef enum logic {StHunt, StCollect} state_e;

  state_e      state_q, state_d;
  logic [1:0]  pos_q, pos_d;
  logic        accept, drop_err;
  logic [1:0]  acc_pos;

  // Scaling by 181/256 approximates cos(45 deg); the slice is an arithmetic shift right by 8.
  function automatic logic signed [CW-1:0] diag(input logic signed [SW-1:0] x);
    logic signed [PW-1:0] p;
    p = {{9{x[SW-1]}}, x} * PW'(181);
    return p[CW+7:8];
  endfunction

  // Framing FSM: state register
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= StHunt;
      pos_q   <= 2'd0;
    end else if (iclkena) begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // Framing FSM: next state
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if (ival) begin
      unique case (state_q)
        StHunt: begin
          if (isop) begin
            state_d = StCollect;
            pos_d   = 2'd1;
          end
        end
        StCollect: begin
          if (isop) begin
            pos_d = 2'd1;
          end else if (pos_q == 2'd3) begin
            state_d = StHunt;
            pos_d   = 2'd0;
          end else begin
            pos_d = 2'(pos_q + 2'd1);
          end
        end
      endcase
    end
  end

  // Framing FSM: outputs
  always_comb begin
    accept   = 1'b0;
    drop_err = 1'b0;
    acc_pos  = pos_q;
    if (ival) begin
      unique case (state_q)
        StHunt: begin
          accept   = isop;
          drop_err = ~isop;
          acc_pos  = 2'd0;
        end
        StCollect: begin
          accept   = 1'b1;
          drop_err = isop;
          acc_pos  = isop ? 2'd0 : pos_q;
        end
      endcase
    end
  end

  // Stage 1: register sample, position and sum/difference
  logic                     s1_val_q;
  logic [1:0]               s1_pos_q;
  logic signed [pDAT_W-1:0] s1_re_q, s1_im_q;
  logic signed [SW-1:0]     s1_s_q, s1_d_q;
  logic signed [SW-1:0]     re_x, im_x;
  logic                     oerr_q;

  assign re_x = {idat_re[pDAT_W-1], idat_re};
  assign im_x = {idat_im[pDAT_W-1], idat_im};

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      s1_val_q <= 1'b0;
      s1_pos_q <= 2'd0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
      s1_s_q   <= '0;
      s1_d_q   <= '0;
      oerr_q   <= 1'b0;
    end else if (iclkena) begin
      s1_val_q <= accept;
      oerr_q   <= drop_err;
      if (accept) begin
        s1_pos_q <= acc_pos;
        s1_re_q  <= idat_re;
        s1_im_q  <= idat_im;
        s1_s_q   <= re_x + im_x;
        s1_d_q   <= re_x - im_x;
      end
    end
  end

  // Stage 2: correlations against the eight constellation points
  logic signed [CW-1:0] corr_d [8];
  logic signed [CW-1:0] corr_q [8];
  logic                 s2_val_q;
  logic [1:0]           s2_pos_q;
  logic signed [CW-1:0] re_c, im_c, diag_s;

  always_comb begin
    re_c   = {{2{s1_re_q[pDAT_W-1]}}, s1_re_q};
    im_c   = {{2{s1_im_q[pDAT_W-1]}}, s1_im_q};
    diag_s = diag(s1_s_q);
    corr_d[0] = re_c;
    corr_d[1] = diag_s;
    corr_d[2] = im_c;
    // Scale the negated difference so point 3 rounds toward -inf like point 7's mirror image.
    corr_d[3] = diag(-s1_d_q);
    corr_d[4] = -re_c;
    corr_d[5] = -diag_s;
    corr_d[6] = -im_c;
    corr_d[7] = diag(s1_d_q);
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      s2_val_q <= 1'b0;
      s2_pos_q <= 2'd0;
      for (int k = 0; k < 8; k++) corr_q[k] <= '0;
    end else if (iclkena) begin
      s2_val_q <= s1_val_q;
      if (s1_val_q) begin
        s2_pos_q <= s1_pos_q;
        for (int k = 0; k < 8; k++) corr_q[k] <= corr_d[k];
      end
    end
  end

  // Stage 3: offset-binary metrics written into the frame slot
  logic signed [CW-1:0] half [8];
  logic [pDAT_W-1:0]    met  [8];
  logic                 oval_q;
  logic [32*pDAT_W-1:0] symb_q;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      half[k] = corr_q[k] >>> 1;
      met[k]  = half[k][pDAT_W-1:0] + {1'b1, {(pDAT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oval_q <= 1'b0;
      symb_q <= '0;
    end else if (iclkena) begin
      oval_q <= s2_val_q && (s2_pos_q == 2'd3);
      if (s2_val_q) begin
        for (int k = 0; k < 8; k++) begin
          symb_q[(int'(s2_pos_q) * 8 + k) * pDAT_W +: pDAT_W] <= met[k];
        end
      end
    end
  end

  assign oval    = oval_q;
  assign oerr    = oerr_q;
  assign osymb_m = symb_q;

endmodule

// File: tb/tb_tcm_dec_symb_metric.sv
// Randomised self-checking bench for tcm_dec_symb_metric against a frame-level reference model.
module tb_tcm_dec_symb_metric;

  logic              iclk = 1'b0;
  logic              ireset, iclkena, ival, isop;
  logic signed [7:0] idat_re, idat_im;
  logic              oval, oerr;
  logic [255:0]      osymb_m;

  tcm_dec_symb_metric #(.pDAT_W(8)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (ival),
    .isop    (isop),
    .idat_re (idat_re),
    .idat_im (idat_im),
    .oval    (oval),
    .osymb_m (osymb_m),
    .oerr    (oerr)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit  hunting;
  int  npos, ecyc, cyc;
  bit  pend_v [4];
  int  pend_pos [4];
  int  pend_m [4][8];
  int  exp_m [4][8];
  bit  exp_oval, exp_oerr;
  int  oval_cnt, oerr_cnt, last_oval_cyc;
  logic [255:0] cap_m;

  function automatic int diag(input int x);
    return (x * 181) >>> 8;
  endfunction

  // Correlation with the point at k*45 deg, then offset-binary metric.
  function automatic int metric(input int re, input int im, input int k);
    int s, d, c;
    s = re + im;
    d = re - im;
    case (k)
      0: c = re;
      1: c = diag(s);
      2: c = im;
      3: c = diag(-d);
      4: c = -re;
      5: c = -diag(s);
      6: c = -im;
      default: c = diag(d);
    endcase
    return ((c >>> 1) + 128) & 255;
  endfunction

  function automatic logic [255:0] pack_exp();
    logic [255:0] v;
    int m;
    v = '0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) begin
        m = exp_m[p][k];
        v[(p*8+k)*8 +: 8] = m[7:0];
      end
    return v;
  endfunction

  function automatic int fld(input logic [255:0] v, input int p, input int k);
    return int'(v[(p*8+k)*8 +: 8]);
  endfunction

  task automatic model_reset();
    hunting = 1'b1;
    npos = 0;
    exp_oval = 1'b0;
    exp_oerr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pend_v[i] = 1'b0;
      for (int k = 0; k < 8; k++) exp_m[i][k] = 0;
    end
  endtask

  task automatic step(input bit ena, input bit val, input bit sop, input int re, input int im);
    bit err, acc;
    int apos, slot;
    iclkena = ena;
    ival    = val;
    isop    = sop;
    idat_re = 8'(re);
    idat_im = 8'(im);
    @(posedge iclk);
    #1;
    cyc++;
    if (ena) begin
      ecyc++;
      err = 1'b0;
      acc = 1'b0;
      apos = 0;
      if (val) begin
        if (hunting) begin
          if (sop) begin
            acc = 1'b1; apos = 0; hunting = 1'b0; npos = 1;
          end else begin
            err = 1'b1;
          end
        end else if (sop) begin
          err = 1'b1; acc = 1'b1; apos = 0; npos = 1;
        end else begin
          acc = 1'b1; apos = npos; npos++;
          if (npos == 4) begin
            hunting = 1'b1; npos = 0;
          end
        end
      end
      // Metrics of a sample accepted now become visible two enabled edges later.
      if (acc) begin
        slot = (ecyc + 2) % 4;
        pend_v[slot] = 1'b1;
        pend_pos[slot] = apos;
        for (int k = 0; k < 8; k++) pend_m[slot][k] = metric(re, im, k);
      end
      exp_oerr = err;
      exp_oval = 1'b0;
      slot = ecyc % 4;
      if (pend_v[slot]) begin
        for (int k = 0; k < 8; k++) exp_m[pend_pos[slot]][k] = pend_m[slot][k];
        exp_oval = (pend_pos[slot] == 3);
        pend_v[slot] = 1'b0;
      end
      if (oval) begin
        oval_cnt++;
        cap_m = osymb_m;
        last_oval_cyc = cyc;
      end
      if (oerr) oerr_cnt++;
    end
    check("oval", oval, exp_oval);
    check("oerr", oerr, exp_oerr);
    check("osymb_m", osymb_m, pack_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    iclkena = 1'b1;
    ival = 1'b0;
    isop = 1'b0;
    @(posedge iclk);
    #1;
    model_reset();
    ireset = 1'b0;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  int last;
  int ref0 [8] = '{178, 163, 128, 92, 78, 93, 128, 163};

  initial begin
    ireset = 1'b1; iclkena = 1'b0; ival = 1'b0; isop = 1'b0;
    idat_re = '0; idat_im = '0;
    cyc = 0; ecyc = 0; oval_cnt = 0; oerr_cnt = 0; last_oval_cyc = 0; cap_m = '0;
    model_reset();
    repeat (2) @(posedge iclk);
    #1;
    check("rst_oval", oval, 1'b0);
    check("rst_oerr", oerr, 1'b0);
    check("rst_symb", osymb_m, 256'd0);
    ireset = 1'b0;

    // Single frame
    oval_cnt = 0;
    step(1, 1, 1, 100, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    last = cyc;
    idle(4);
    check("single_cnt", oval_cnt, 1);
    check("single_lat", last_oval_cyc - last, 2);
    for (int k = 0; k < 8; k++) check("single_p0", fld(cap_m, 0, k), ref0[k]);
    for (int p = 1; p < 4; p++)
      for (int k = 0; k < 8; k++) check("single_px", fld(cap_m, p, k), 128);

    // Extreme inputs
    oval_cnt = 0;
    step(1, 1, 1, -128, -128);
    for (int i = 0; i < 3; i++) step(1, 1, 0, -128, -128);
    idle(4);
    check("ext_cnt", oval_cnt, 1);
    for (int p = 0; p < 4; p++) begin
      check("ext_k1", fld(cap_m, p, 1), 37);
      check("ext_k5", fld(cap_m, p, 5), 218);
      check("ext_k4", fld(cap_m, p, 4), 192);
      check("ext_k0", fld(cap_m, p, 0), 64);
    end

    // Continuous stream of three frames
    oval_cnt = 0; oerr_cnt = 0;
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 4; p++) step(1, 1, p == 0, rnd(), rnd());
    idle(4);
    check("stream_cnt", oval_cnt, 3);
    check("stream_err", oerr_cnt, 0);

    // Framing errors
    do_reset();
    oval_cnt = 0; oerr_cnt = 0;
    step(1, 1, 0, 5, 5);
    idle(4);
    check("nosop_err", oerr_cnt, 1);
    check("nosop_cnt", oval_cnt, 0);
    oval_cnt = 0; oerr_cnt = 0;
    step(1, 1, 1, rnd(), rnd());
    step(1, 1, 0, rnd(), rnd());
    step(1, 1, 1, rnd(), rnd());
    for (int i = 0; i < 3; i++) step(1, 1, 0, rnd(), rnd());
    idle(4);
    check("resop_err", oerr_cnt, 1);
    check("resop_cnt", oval_cnt, 1);

    // Clock enable gap after the last sample
    oval_cnt = 0;
    step(1, 1, 1, rnd(), rnd());
    for (int i = 0; i < 3; i++) step(1, 1, 0, rnd(), rnd());
    last = cyc;
    idle(1);
    for (int i = 0; i < 5; i++) step(0, 1, 1'($urandom_range(0, 1)), rnd(), rnd());
    idle(4);
    check("ena_cnt", oval_cnt, 1);
    check("ena_lat", last_oval_cyc - last, 7);

    // Asynchronous reset mid-frame
    step(1, 1, 1, rnd(), rnd());
    step(1, 1, 0, rnd(), rnd());
    #2;
    ireset = 1'b1;
    #1;
    check("amid_oval", oval, 1'b0);
    check("amid_oerr", oerr, 1'b0);
    check("amid_symb", osymb_m, 256'd0);
    model_reset();
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    oval_cnt = 0; oerr_cnt = 0;
    step(1, 1, 0, rnd(), rnd());
    idle(4);
    check("amid_cnt", oval_cnt, 0);
    check("amid_hunt", oerr_cnt, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           rnd(), rnd());
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
